// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned MD_CNT_W = $clog2(MD_WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

   typedef enum logic {MD_MUL, MD_DIV} md_op_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Bit-serial shift-add multiplier / restoring divider with sign fixup.
// MULDIV_EARLY_OUT_EN exports a flag telling the sequencer the multiplier has no set bits left.
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  md_op_t           op,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
`ifdef MULDIV_EARLY_OUT_EN
   output logic             mplr_rest_zero,
`endif
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res
);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] opb;
   logic [WIDTH-1:0]   mplr;
   logic               neg_a;
   logic               neg_b;
   md_op_t             op_q;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [WIDTH:0]     div_up;
   logic               div_fit;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   assign a_neg = signed_op & src_a[WIDTH-1];
   assign b_neg = signed_op & src_b[WIDTH-1];
   assign a_mag = a_neg ? -src_a : src_a;
   assign b_mag = b_neg ? -src_b : src_b;

`ifdef MULDIV_EARLY_OUT_EN
   assign mplr_rest_zero = (mplr[WIDTH-1:1] == '0);
`endif

   // Restoring divide step: shift remainder:quotient left, trial-subtract divisor.
   always_comb begin
      div_up   = acc[2*WIDTH-1:WIDTH-1];
      div_fit  = (div_up >= {1'b0, opb[WIDTH-1:0]});
      div_diff = div_up[WIDTH-1:0] - opb[WIDTH-1:0];
      div_next = {acc[2*WIDTH-2:0], 1'b0};
      if (div_fit) begin
         div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
      end
   end

   // Operand capture at start, then one multiply or divide iteration per step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         opb      <= '0;
         mplr     <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         op_q     <= MD_MUL;
         div_zero <= 1'b0;
      end else if (load) begin
         acc      <= (op == MD_MUL) ? '0 : {{WIDTH{1'b0}}, a_mag};
         opb      <= {{WIDTH{1'b0}}, (op == MD_MUL) ? a_mag : b_mag};
         mplr     <= b_mag;
         neg_a    <= a_neg;
         neg_b    <= b_neg;
         op_q     <= op;
         div_zero <= (src_b == '0);
      end else if (step) begin
         if (op_q == MD_MUL) begin
            acc  <= acc + (mplr[0] ? opb : '0);
            opb  <= opb << 1;
            mplr <= mplr >> 1;
         end else begin
            acc <= div_next;
         end
      end
   end

   // Sign fixup of the finished result; divide-by-zero returns the raw dividend in HI.
   always_comb begin
      prod   = (neg_a ^ neg_b) ? -acc : acc;
      quo    = acc[WIDTH-1:0];
      rem    = acc[2*WIDTH-1:WIDTH];
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
      if (op_q == MD_DIV) begin
         if (div_zero) begin
            lo_res = '1;
            hi_res = neg_a ? -quo : quo;
         end else begin
            lo_res = (neg_a ^ neg_b) ? -quo : quo;
            hi_res = neg_a ? -rem : rem;
         end
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: FSM, iteration counter, HI/LO registers and decode stall request.
// MULDIV_EARLY_OUT_EN: multiply finishes once no multiplier bits remain set.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             StartMulE,
   input  logic             StartDivE,
   input  logic             SignedE,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic             MthiE,
   input  logic             MtloE,
   input  logic             MdOpD,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Busy,
   output logic             StallMD
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   md_state_t        state;
   md_state_t        state_nxt;
   logic [CNT_W-1:0] count;
   logic             load;
   logic             step;
   logic             write;
   md_op_t           op_sel;
   logic             div_zero;
   logic [WIDTH-1:0] hi_res;
   logic [WIDTH-1:0] lo_res;
`ifdef MULDIV_EARLY_OUT_EN
   logic             mplr_rest_zero;
`endif

   muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk            (clk),
      .rst            (rst),
      .load           (load),
      .step           (step),
      .op             (op_sel),
      .signed_op      (SignedE),
      .src_a          (SrcAE),
      .src_b          (SrcBE),
`ifdef MULDIV_EARLY_OUT_EN
      .mplr_rest_zero (mplr_rest_zero),
`endif
      .div_zero       (div_zero),
      .hi_res         (hi_res),
      .lo_res         (lo_res)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and datapath controls; multiply has priority over divide.
   // A zero divisor spends one cycle in DIV without iterating, then goes to FIX.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      write     = 1'b0;
      op_sel    = StartMulE ? MD_MUL : MD_DIV;
      case (state)
         IDLE: begin
            if (StartMulE) begin
               load      = 1'b1;
               state_nxt = MUL;
`ifdef MULDIV_EARLY_OUT_EN
               if (SrcBE == '0) begin
                  state_nxt = FIX;
               end
`endif
            end else if (StartDivE) begin
               load      = 1'b1;
               state_nxt = DIV;
            end
         end
         MUL: begin
            step = 1'b1;
            if (count == LAST) begin
               state_nxt = FIX;
            end
`ifdef MULDIV_EARLY_OUT_EN
            if (mplr_rest_zero) begin
               state_nxt = FIX;
            end
`endif
         end
         DIV: begin
            if (div_zero) begin
               state_nxt = FIX;
            end else begin
               step = 1'b1;
               if (count == LAST) begin
                  state_nxt = FIX;
               end
            end
         end
         FIX: begin
            write     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Iteration counter, cleared at start and advanced per datapath step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (step) begin
         count <= count + 1'b1;
      end
   end

   // HI/LO: result write on FIX, MTHI/MTLO only when idle with no start pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         HI <= '0;
         LO <= '0;
      end else if (write) begin
         HI <= hi_res;
         LO <= lo_res;
      end else if (state == IDLE && !StartMulE && !StartDivE) begin
         if (MthiE) begin
            HI <= SrcAE;
         end
         if (MtloE) begin
            LO <= SrcAE;
         end
      end
   end

   assign Busy    = (state != IDLE);
   assign StallMD = MdOpD & (Busy | StartMulE | StartDivE);

endmodule
